// File: rtl/demux7out_buf_if.sv
// rtl/demux7out_buf_if.sv - input/output handshake bundle for the buffered 1-to-7 router
interface demux7out_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       Order;
    logic [WIDTH-1:0] DataIn;
    logic [6:0]       out_valid;
    logic [6:0]       out_ready;
    logic [WIDTH-1:0] DataOut;
    logic             err;

    // Environment side: produces words and consumer readies
    modport master (
        output in_valid, Order, DataIn, out_ready,
        input  in_ready, out_valid, DataOut, err
    );

    // Router side
    modport slave (
        input  in_valid, Order, DataIn, out_ready,
        output in_ready, out_valid, DataOut, err
    );
endinterface

// File: rtl/demux7out_buf.sv
// rtl/demux7out_buf.sv - buffered 1-to-7 router, FIFO of {Order, DataIn}; optional per-channel pop counters under ROUTE_CNT_EN
module demux7out_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    demux7out_buf_if.slave     bus
`ifdef ROUTE_CNT_EN
    ,
    input  logic [2:0]         cnt_sel,
    output logic [15:0]        cnt_val
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [2:0] ILLEGAL_ORDER = 3'b111;

    logic [2:0]       ord_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] last_data;
    logic             err_q;

    logic             not_empty;
    logic             accept;
    logic             push;
    logic             bad_order;
    logic             pop;
    logic [2:0]       head_order;
    logic [WIDTH-1:0] head_data;
    logic [7:0]       head_onehot;
    logic [7:0]       ready_ext;

    // Handshake decode; everything visible on the output side comes from storage or count
    always_comb begin
        not_empty   = (count != '0);
        head_order  = ord_mem[rd_ptr];
        head_data   = data_mem[rd_ptr];
        head_onehot = 8'b1 << head_order;
        // Eighth bit pads the 3-bit index; illegal orders are never stored so it stays unused
        ready_ext   = {1'b0, bus.out_ready};
        accept      = bus.in_valid & bus.in_ready;
        bad_order   = accept & (bus.Order == ILLEGAL_ORDER);
        push        = accept & (bus.Order != ILLEGAL_ORDER);
        pop         = not_empty & ready_ext[head_order];
    end

    // No bypass: a full FIFO refuses input even when a pop is happening
    assign bus.in_ready  = (count < FULL_COUNT);
    assign bus.out_valid = not_empty ? head_onehot[6:0] : 7'b0;
    // When empty, the last popped word stays on the bus (0 after reset)
    assign bus.DataOut   = not_empty ? head_data : last_data;
    assign bus.err       = err_q;

    // FIFO storage: written only for legal orders
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ord_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            ord_mem[wr_ptr]  <= bus.Order;
            data_mem[wr_ptr] <= bus.DataIn;
        end
    end

    // Pointers, occupancy, held output word and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= head_data;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bad_order) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef ROUTE_CNT_EN
    logic [15:0] route_cnt [7];
    logic [15:0] cnt_mux;

    // One wrapping pop counter per destination channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 7; k++) begin
                route_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (pop && (head_order == 3'(k))) begin
                    route_cnt[k] <= route_cnt[k] + 16'd1;
                end
            end
        end
    end

    // Counter readback select; selector value 7 reads as zero
    always_comb begin
        cnt_mux = '0;
        for (int k = 0; k < 7; k++) begin
            if (cnt_sel == 3'(k)) begin
                cnt_mux = route_cnt[k];
            end
        end
    end

    // Registered readback, one cycle behind cnt_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val <= '0;
        end else begin
            cnt_val <= cnt_mux;
        end
    end
`endif

endmodule

// File: tb/tb_demux7out_buf.sv
// tb/tb_demux7out_buf.sv - self-checking bench for demux7out_buf against a queue-based reference
module tb_demux7out_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [2:0]  ord;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic rst_n;
`ifdef ROUTE_CNT_EN
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_val;
`endif

    demux7out_buf_if #(.WIDTH(WIDTH)) bus ();

    demux7out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef ROUTE_CNT_EN
        ,
        .cnt_sel (cnt_sel),
        .cnt_val (cnt_val)
`endif
    );

    // Reference model: a queue of pending words plus the observable side state
    entry_t      q[$];
    logic [31:0] m_last;
    logic        m_err;
    int          m_cnt[7];

    int n_pass;
    int n_total;
    int n_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_err  = 1'b0;
        for (int k = 0; k < 7; k++) m_cnt[k] = 0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge
    task automatic cycle(output bit acc);
        logic [6:0]  exp_valid;
        logic [31:0] exp_data;
        bit          exp_ready;
        bit          popped;
        @(negedge clk);
        exp_ready = (q.size() < DEPTH);
        exp_valid = '0;
        exp_data  = m_last;
        if (q.size() > 0) begin
            exp_valid[q[0].ord] = 1'b1;
            exp_data            = q[0].data;
        end
        check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check("DataOut",   64'(bus.DataOut),   64'(exp_data));
        check("err",       64'(bus.err),       64'(m_err));
        acc    = bus.in_valid && exp_ready;
        popped = (q.size() > 0) && bus.out_ready[q[0].ord];
        @(posedge clk);
        n_cycles++;
        if (popped) begin
            m_last = q[0].data;
            m_cnt[q[0].ord]++;
            void'(q.pop_front());
        end
        if (acc) begin
            if (bus.Order == 3'b111) m_err = 1'b1;
            else q.push_back('{ord: bus.Order, data: bus.DataIn});
        end
        #1;
    endtask

    // Offer one word and hold it until accepted, within a bounded number of cycles
    task automatic send(input logic [2:0] ord, input logic [31:0] data);
        bit acc;
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.Order    = ord;
        bus.DataIn   = data;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(acc);
            got = acc;
        end
        if (!got) check("send_accept", 64'(got), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        int start;
        n_pass = 0; n_total = 0; n_cycles = 0;
        model_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Order     = '0;
        bus.DataIn    = '0;
        bus.out_ready = '0;
`ifdef ROUTE_CNT_EN
        cnt_sel = '0;
`endif
        // Reset state
        #3;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_DataOut",   64'(bus.DataOut),   64'd0);
        check("rst_err",       64'(bus.err),       64'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word to channel 3, consumer ready
        bus.out_ready = 7'h7F;
        send(3'd3, 32'hA5A5_0003);
        idle(2);

        // Fill with consumers stalled; third word is held by the sender
        bus.out_ready = 7'h00;
        send(3'd0, 32'h1000_0000);
        send(3'd1, 32'h1000_0001);
        bus.in_valid = 1'b1;
        bus.Order    = 3'd2;
        bus.DataIn   = 32'h1000_0002;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            check("held_while_full", 64'(acc), 64'd0);
        end
        // Wrong-channel readiness must not pop the head
        bus.out_ready = 7'h7E;
        cycle(acc);
        check("wrong_ready_no_pop", 64'(acc), 64'd0);
        // Release channel 0: pop occurs, push waits until the next cycle
        bus.out_ready = 7'h01;
        cycle(acc);
        check("no_push_on_full_pop", 64'(acc), 64'd0);
        send(3'd2, 32'h1000_0002);
        bus.out_ready = 7'h7F;
        idle(3);

        // Illegal order is swallowed and sets the sticky flag
        send(3'd7, 32'hDEAD_BEEF);
        idle(1);
        send(3'd6, 32'h6666_0006);
        idle(2);

        // Stream of 100 words round-robin, full throughput
        start = n_cycles;
        for (int i = 0; i < 100; i++) send(3'(i % 7), $urandom);
        check("stream_cycles", 64'(n_cycles - start), 64'd100);
        idle(2);
`ifdef ROUTE_CNT_EN
        cnt_sel = 3'd2;
        idle(2);
        check("cnt_val_ch2", 64'(cnt_val), 64'(m_cnt[2]));
        cnt_sel = 3'd7;
        idle(2);
        check("cnt_val_sel7", 64'(cnt_val), 64'd0);
`endif

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.Order     = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            bus.DataIn    = $urandom;
            bus.out_ready = 7'($urandom);
            cycle(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 7'h7F;
        idle(3);
`ifdef ROUTE_CNT_EN
        for (int k = 0; k < 7; k++) begin
            cnt_sel = 3'(k);
            idle(2);
            check("cnt_val_rand", 64'(cnt_val), 64'(m_cnt[k] % 65536));
        end
`endif

        // Asynchronous reset with two words queued
        bus.out_ready = 7'h00;
        send(3'd4, 32'h4444_0004);
        send(3'd5, 32'h5555_0005);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready",  64'(bus.in_ready),  64'd1);
        check("arst_err",       64'(bus.err),       64'd0);
        check("arst_DataOut",   64'(bus.DataOut),   64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 7'h7F;
        @(posedge clk); #1;
        send(3'd5, 32'h0BAD_CAFE);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
